// File: rtl/comm_pkg.sv
// Shared constants for the comm chain: frame sequencer state codes and
// default payload and preamble settings shared with the encoder.
package comm_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam int         SYNC_W_DEF    = 8;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/comm_bit_timer.sv
// Bit-period divider: counts sysclk cycles within a bit and flags the last one.
module comm_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_strb
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Held at zero whenever the sequencer is not running, so every frame starts on a fresh period.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (clear || !run)
      div_cnt <= '0;
    else if (div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + CNT_W'(1);
  end

  assign bit_strb = run && (div_cnt == LAST);

endmodule

// File: rtl/comm_frame_seq.sv
// Frame sequencer: serialises each latched word as sync, data, parity and gap bits,
// and applies the monitor tap select only at frame boundaries.
module comm_frame_seq
  import comm_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CLK_DIV   = 4,
  parameter int                SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                GAP_BITS  = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        out_select,
  output logic              tx_bit,
  output logic              bit_strb,
  output logic              load_strb,
  output logic              frame_sync,
  output logic [7:0]        frame_cnt,
  output logic [1:0]        mux_sel,
  output logic              busy
);

  localparam int MAX_BITS = max3(SYNC_W, DATA_W, GAP_BITS);
  localparam int IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  logic [2:0]        state;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [DATA_W-1:0] shadow;
  logic [SYNC_W-1:0] sync_shift;
  logic [DATA_W-1:0] data_shift;
  logic              last_bit;
  logic              start;

  assign busy       = (state != ST_IDLE);
  assign frame_sync = (state == ST_SYNC);

  comm_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .sysclk   (sysclk),
    .reset    (reset),
    .clear    (start),
    .run      (busy),
    .bit_strb (bit_strb)
  );

  always_comb begin
    last_idx = '0;
    case (state)
      ST_SYNC: last_idx = IDX_W'(SYNC_W - 1);
      ST_DATA: last_idx = IDX_W'(DATA_W - 1);
      ST_GAP:  last_idx = IDX_W'(GAP_BITS - 1);
      default: last_idx = '0;
    endcase
  end

  assign last_bit = bit_strb && (bit_idx == last_idx);
  // A new frame may begin from IDLE or directly off the final gap strobe, with no dead cycle.
  assign start    = enable && ((state == ST_IDLE) || ((state == ST_GAP) && last_bit));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      shadow    <= '0;
      load_strb <= 1'b0;
    end else begin
      load_strb <= start;
      if (start) begin
        shadow  <= data_in;
        state   <= ST_SYNC;
        bit_idx <= '0;
      end else if (bit_strb) begin
        if (last_bit) begin
          bit_idx <= '0;
          case (state)
            ST_SYNC:   state <= ST_DATA;
            ST_DATA:   state <= ST_PARITY;
            ST_PARITY: state <= ST_GAP;
            default:   state <= ST_IDLE;
          endcase
        end else begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

  // The tap follows the request freely while idle but is frozen for the length of a frame.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      mux_sel   <= 2'b00;
      frame_cnt <= 8'd0;
    end else begin
      if (start || (state == ST_IDLE))
        mux_sel <= out_select;
      if ((state == ST_PARITY) && bit_strb)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign sync_shift = SYNC_WORD << bit_idx;
  assign data_shift = shadow << bit_idx;

  always_comb begin
    tx_bit = 1'b0;
    case (state)
      ST_SYNC:   tx_bit = sync_shift[SYNC_W-1];
      ST_DATA:   tx_bit = data_shift[DATA_W-1];
      ST_PARITY: tx_bit = ^shadow;
      default:   tx_bit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_comm_frame_seq.sv
// Self-checking bench for comm_frame_seq: a frame-level model compared every cycle,
// plus directed frames with hand-computed bit patterns.
module tb_comm_frame_seq;

  localparam int         CLK_DIV   = 4;
  localparam int         SYNC_W    = 8;
  localparam int         DATA_W    = 8;
  localparam int         GAP_BITS  = 2;
  localparam logic [7:0] SYNC_WORD = 8'hA5;
  localparam int         NBITS     = SYNC_W + DATA_W + 1 + GAP_BITS;
  localparam int         FRAME_LEN = NBITS * CLK_DIV;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] out_select = 2'b00;
  logic       tx_bit, bit_strb, load_strb, frame_sync, busy;
  logic [7:0] frame_cnt;
  logic [1:0] mux_sel;

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  comm_frame_seq #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .SYNC_W(SYNC_W),
    .SYNC_WORD(SYNC_WORD), .GAP_BITS(GAP_BITS)
  ) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .data_in(data_in),
    .out_select(out_select), .tx_bit(tx_bit), .bit_strb(bit_strb),
    .load_strb(load_strb), .frame_sync(frame_sync), .frame_cnt(frame_cnt),
    .mux_sel(mux_sel), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is just a list of bits, each held CLK_DIV cycles.
  logic             m_idle = 1'b1;
  int               m_pos = 0;
  logic [NBITS-1:0] m_bits = '0;
  logic [7:0]       m_cnt = 8'd0;
  logic [1:0]       m_sel = 2'b00;
  logic             m_load = 1'b0;

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
    return {SYNC_WORD, d, ^d, {GAP_BITS{1'b0}}};
  endfunction

  task automatic model_start();
    m_bits = frame_bits(data_in);
    m_pos  = 0;
    m_idle = 1'b0;
    m_load = 1'b1;
    m_sel  = out_select;
  endtask

  initial forever begin
    @(posedge sysclk or posedge reset);
    if (reset) begin
      m_idle = 1'b1; m_pos = 0; m_cnt = 8'd0; m_sel = 2'b00; m_load = 1'b0;
    end else begin
      m_load = 1'b0;
      if (m_idle) begin
        m_sel = out_select;
        if (enable) model_start();
      end else begin
        m_pos++;
        if (m_pos == (SYNC_W + DATA_W + 1) * CLK_DIV) m_cnt++;
        if (m_pos == FRAME_LEN) begin
          if (enable) model_start();
          else begin m_idle = 1'b1; m_pos = 0; end
        end
      end
    end
  end

  initial forever begin
    logic [NBITS-1:0] sh;
    @(posedge sysclk);
    #1;
    if (!done) begin
      sh = m_bits << (m_pos / CLK_DIV);
      check("busy",       32'(busy),       32'(!m_idle));
      check("tx_bit",     32'(tx_bit),     32'(!m_idle && sh[NBITS-1]));
      check("frame_sync", 32'(frame_sync), 32'(!m_idle && (m_pos < SYNC_W * CLK_DIV)));
      check("bit_strb",   32'(bit_strb),   32'(!m_idle && (m_pos % CLK_DIV == CLK_DIV - 1)));
      check("load_strb",  32'(load_strb),  32'(m_load));
      check("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
      check("mux_sel",    32'(mux_sel),    32'(m_sel));
    end
  end

  // Captures one frame's worth of cycles, optionally changing inputs at cycle chg_at.
  task automatic applyStimulus(input int chg_at, input logic [7:0] nd, input logic [1:0] ns,
                               input logic ne, output logic [NBITS-1:0] bits,
                               output int sync_cnt, output int load_cnt, output logic first_sync);
    bits = '0; sync_cnt = 0; load_cnt = 0; first_sync = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(posedge sysclk);
      #1;
      if (i == 0) first_sync = frame_sync;
      if (i % CLK_DIV == 1) bits = {bits[NBITS-2:0], tx_bit};
      sync_cnt += int'(frame_sync);
      load_cnt += int'(load_strb);
      if (i == chg_at) begin data_in = nd; out_select = ns; enable = ne; end
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".tx_bit"},     32'(tx_bit),     32'(0));
    check({tag, ".bit_strb"},   32'(bit_strb),   32'(0));
    check({tag, ".load_strb"},  32'(load_strb),  32'(0));
    check({tag, ".frame_sync"}, 32'(frame_sync), 32'(0));
    check({tag, ".frame_cnt"},  32'(frame_cnt),  32'(0));
    check({tag, ".mux_sel"},    32'(mux_sel),    32'(0));
    check({tag, ".busy"},       32'(busy),       32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NBITS-1:0] bits;
    int sc, lc;
    logic fs;

    repeat (3) @(negedge sysclk);
    checkOutput("reset");
    reset = 1'b0;

    @(negedge sysclk);
    enable = 1'b1; data_in = 8'h69; out_select = 2'b00;
    applyStimulus(10, 8'hEF, 2'b00, 1'b1, bits, sc, lc, fs);
    check("f1.bits",      32'(bits), 32'(19'b1010010101101001000));
    check("f1.sync_cyc",  32'(sc),   32'(32));
    check("f1.load_cnt",  32'(lc),   32'(1));
    check("f1.frame_cnt", 32'(frame_cnt), 32'(1));

    applyStimulus(40, 8'h12, 2'b01, 1'b1, bits, sc, lc, fs);
    check("f2.first_sync", 32'(fs),   32'(1));
    check("f2.bits",       32'(bits), 32'(19'b1010010111101111100));
    check("f2.frame_cnt",  32'(frame_cnt), 32'(2));
    check("f2.mux_sel",    32'(mux_sel),   32'(0));

    applyStimulus(40, 8'h12, 2'b01, 1'b0, bits, sc, lc, fs);
    check("f3.bits",      32'(bits), 32'(19'b1010010100010010000));
    check("f3.mux_sel",   32'(mux_sel),   32'(1));
    check("f3.frame_cnt", 32'(frame_cnt), 32'(3));
    repeat (6) begin
      @(posedge sysclk);
      #1;
      check("idle.busy",     32'(busy),     32'(0));
      check("idle.tx_bit",   32'(tx_bit),   32'(0));
      check("idle.bit_strb", 32'(bit_strb), 32'(0));
    end

    @(negedge sysclk);
    out_select = 2'b11;
    @(posedge sysclk);
    #1;
    check("idle.mux_sel", 32'(mux_sel), 32'(3));

    @(negedge sysclk);
    enable = 1'b1; data_in = 8'hC3;
    repeat (41) @(posedge sysclk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst");
    data_in = 8'h3C;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    applyStimulus(-1, 8'h00, 2'b11, 1'b1, bits, sc, lc, fs);
    check("f4.first_sync", 32'(fs),   32'(1));
    check("f4.sync_cyc",   32'(sc),   32'(32));
    check("f4.bits",       32'(bits), 32'(19'b1010010100111100000));
    check("f4.frame_cnt",  32'(frame_cnt), 32'(1));

    for (int k = 1; k <= 255; k++) begin
      applyStimulus(5, 8'(k), 2'(k), (k != 255), bits, sc, lc, fs);
      if (k == 254) check("wrap.pre", 32'(frame_cnt), 32'(255));
    end
    check("wrap.post", 32'(frame_cnt), 32'(0));

    repeat (FRAME_LEN + 4) @(posedge sysclk);
    #1;
    check("end.busy", 32'(busy), 32'(0));

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
